// File: rtl/equiv_sweep_ctrl.sv
// equiv_sweep_ctrl: exhaustive equivalence sequencer for a canonical/minimised
// combinational block pair. It drives every input combination onto the block
// under test, compares each canonical output with its minimised twin, and
// reports the mismatch count, the first failing vector and its output mask.
//
// Optional build macro: EQUIV_STOP_ON_FAIL_EN
//   When defined, the first mismatch ends the sweep at once. vec then holds
//   the failing vector so it can be inspected on the board LEDs.
//   When undefined, every sweep runs through all 2^W_IN vectors.
//
// SETTLE must be in the range 1..15, which fits the 4-bit settle counter.

module equiv_sweep_ctrl #(
    parameter int unsigned W_IN   = 4,
    parameter int unsigned W_OUT  = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [W_IN-1:0]   vec,
    input  logic [W_OUT-1:0]  f_ref,
    input  logic [W_OUT-1:0]  f_min,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [W_IN:0]     err_cnt,
    output logic [W_IN-1:0]   first_vec,
    output logic [W_OUT-1:0]  first_mask
);

    localparam int unsigned CW    = 4;
    localparam int unsigned W_CNT = W_IN + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [W_OUT-1:0] diff_c;
    logic             mismatch_c;
    logic             sample_c;
    logic             last_c;
    logic             first_err_c;

    // Compare terms for the vector currently held on the block under test
    assign diff_c      = f_ref ^ f_min;
    assign mismatch_c  = |diff_c;
    assign sample_c    = (cnt == CW'(SETTLE - 1));
    assign last_c      = (vec == {W_IN{1'b1}});
    assign first_err_c = (err_cnt == '0);

    // Sweep sequencer: state, vector stepping, settle timing and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_vec  <= '0;
            first_mask <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start outranks a simultaneous abort here
                    if (start) begin
                        state      <= RUN;
                        cnt        <= '0;
                        vec        <= '0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        first_vec  <= '0;
                        first_mask <= '0;
                    end
                end

                RUN: begin
                    if (abort) begin
                        // partial err_cnt / first_* are kept for inspection
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (sample_c) begin
                        cnt <= '0;
                        if (mismatch_c) begin
                            err_cnt <= err_cnt + W_CNT'(1);
                            if (first_err_c) begin
                                first_vec  <= vec;
                                first_mask <= diff_c;
                            end
                        end
`ifdef EQUIV_STOP_ON_FAIL_EN
                        if (mismatch_c) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b0;
                        end else if (last_c) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= first_err_c;
                        end else begin
                            vec <= vec + W_IN'(1);
                        end
`else
                        if (last_c) begin
                            // vec holds the last vector rather than wrapping
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= first_err_c && !mismatch_c;
                        end else begin
                            vec <= vec + W_IN'(1);
                        end
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                FIN: begin
                    // start and abort are ignored for this single cycle
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Testbench for equiv_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3), each
// driving a behavioural BUT with a random truth table plus injectable faults.
// Expected sweep outcomes are queued at stimulus time and popped by a monitor.

module tb_equiv_sweep_ctrl;

    localparam int NV = 16;

`ifdef EQUIV_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        bit valid;
        bit done;
        bit pass;
        int err_cnt;
        int first_vec;
        int first_mask;
        int vec;
        int len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_s     [2];
    logic       start_s   [2];
    logic       abort_s   [2];
    logic [3:0] vec_s     [2];
    logic [2:0] f_ref_s   [2];
    logic [2:0] f_min_s   [2];
    logic       busy_s    [2];
    logic       done_s    [2];
    logic       pass_s    [2];
    logic [4:0] err_s     [2];
    logic [3:0] fvec_s    [2];
    logic [2:0] fmask_s   [2];

    logic [2:0] ref_tt [2][NV];
    logic [2:0] fault  [2][NV];
    logic [2:0] glitch [2];

    exp_t q0[$];
    exp_t q1[$];

    int vectors = 0;
    int miscompares = 0;
    int bcnt  [2];
    bit pbusy [2];

    always #5 clk = ~clk;

    equiv_sweep_ctrl #(.W_IN(4), .W_OUT(3), .SETTLE(1)) dut0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .abort(abort_s[0]),
        .vec(vec_s[0]), .f_ref(f_ref_s[0]), .f_min(f_min_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_cnt(err_s[0]), .first_vec(fvec_s[0]), .first_mask(fmask_s[0])
    );

    equiv_sweep_ctrl #(.W_IN(4), .W_OUT(3), .SETTLE(3)) dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .abort(abort_s[1]),
        .vec(vec_s[1]), .f_ref(f_ref_s[1]), .f_min(f_min_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_cnt(err_s[1]), .first_vec(fvec_s[1]), .first_mask(fmask_s[1])
    );

    // Behavioural block under test: truth table, planted faults, glitches
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            f_ref_s[i] = ref_tt[i][vec_s[i]];
            f_min_s[i] = ref_tt[i][vec_s[i]] ^ fault[i][vec_s[i]] ^ glitch[i];
        end
    end

    function automatic int settle_of(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int inst, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s (inst %0d) at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
        end
    endtask

    // Reference outcome of one sweep. kind: 0 full sweep, 1 abort at vector
    // 'at', 2 reset at vector 'at'. Only vectors before 'at' get compared.
    function automatic exp_t model(input int inst, input int kind, input int at);
        exp_t e;
        int swept, errs, fv, fm, stopv, s;
        s = settle_of(inst);
        swept = (kind == 0) ? NV : at;
        errs = 0; fv = 0; fm = 0; stopv = -1;
        for (int v = 0; v < swept; v++) begin
            if (fault[inst][v] != 3'b000) begin
                errs++;
                if (errs == 1) begin
                    fv = v;
                    fm = int'(fault[inst][v]);
                end
                if (STOP) begin
                    stopv = v;
                    break;
                end
            end
        end
        e.valid = 1'b1;
        if (stopv >= 0) begin
            e.done = 1'b1; e.pass = 1'b0; e.err_cnt = 1;
            e.first_vec = fv; e.first_mask = fm; e.vec = stopv; e.len = (stopv + 1) * s;
        end else if (kind == 0) begin
            e.done = 1'b1; e.pass = (errs == 0); e.err_cnt = errs;
            e.first_vec = fv; e.first_mask = fm; e.vec = NV - 1; e.len = NV * s;
        end else if (kind == 1) begin
            e.done = 1'b0; e.pass = 1'b0; e.err_cnt = errs;
            e.first_vec = fv; e.first_mask = fm; e.vec = at; e.len = at * s + 1;
        end else begin
            e.done = 1'b0; e.pass = 1'b0; e.err_cnt = 0;
            e.first_vec = 0; e.first_mask = 0; e.vec = 0; e.len = at * s + 1;
        end
        return e;
    endfunction

    // Monitor: vector stepping per busy cycle, outcome check when busy drops
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit   ev;
            exp_t e;
            ev = pbusy[i] && (busy_s[i] === 1'b0);
            glitch[i] = 3'b000;
            if (busy_s[i] === 1'b1) begin
                chk("vec_step", i, int'(vec_s[i]), bcnt[i] / settle_of(i));
                if (i == 1 && (bcnt[i] % 3) != 2)
                    glitch[i] = 3'($urandom_range(1, 7));
                bcnt[i]++;
            end
            if (ev) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    chk("unexpected_end", i, 1, 0);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk("done",       i, int'(done_s[i]),  int'(e.done));
                    chk("pass",       i, int'(pass_s[i]),  int'(e.pass));
                    chk("err_cnt",    i, int'(err_s[i]),   e.err_cnt);
                    chk("first_vec",  i, int'(fvec_s[i]),  e.first_vec);
                    chk("first_mask", i, int'(fmask_s[i]), e.first_mask);
                    chk("vec_final",  i, int'(vec_s[i]),   e.vec);
                    chk("busy_len",   i, bcnt[i],          e.len);
                end
                bcnt[i] = 0;
            end else if (done_s[i] === 1'b1) begin
                chk("stray_done", i, 1, 0);
            end
            pbusy[i] = (busy_s[i] === 1'b1);
        end
    end

    task automatic clear_faults(input int inst);
        for (int v = 0; v < NV; v++) fault[inst][v] = 3'b000;
    endtask

    task automatic random_tables(input int inst);
        for (int v = 0; v < NV; v++) begin
            ref_tt[inst][v] = 3'($urandom_range(0, 7));
            fault[inst][v]  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        end
    endtask

    // One sweep: optional simultaneous abort with start, optional stray start
    // at cycle 'mid', then abort/reset at vector 'at' for kinds 1/2.
    task automatic run_sweep(input int inst, input int kind, input int at,
                             input bit both, input int mid);
        exp_t e;
        int   s, total;
        s = settle_of(inst);
        e = model(inst, kind, at);
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        start_s[inst] = 1'b1;
        abort_s[inst] = both;
        @(negedge clk);
        start_s[inst] = 1'b0;
        abort_s[inst] = 1'b0;
        total = (kind == 0) ? NV * s + 4 : at * s;
        for (int c = 0; c < total; c++) begin
            if (mid > 0 && c == mid) start_s[inst] = 1'b1;
            @(negedge clk);
            start_s[inst] = 1'b0;
        end
        if (kind != 0) begin
            if (kind == 1) abort_s[inst] = 1'b1; else rst_s[inst] = 1'b1;
            @(negedge clk);
            abort_s[inst] = 1'b0;
            rst_s[inst]   = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; abort_s[i] = 1'b0;
            glitch[i] = 3'b000; bcnt[i] = 0; pbusy[i] = 1'b0;
            for (int v = 0; v < NV; v++) ref_tt[i][v] = 3'($urandom_range(0, 7));
            clear_faults(i);
        end
        repeat (3) @(negedge clk);
        // start held high during reset must not launch a sweep
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy",       i, int'(busy_s[i]),  0);
            chk("rst_done",       i, int'(done_s[i]),  0);
            chk("rst_pass",       i, int'(pass_s[i]),  0);
            chk("rst_err_cnt",    i, int'(err_s[i]),   0);
            chk("rst_first_vec",  i, int'(fvec_s[i]),  0);
            chk("rst_first_mask", i, int'(fmask_s[i]), 0);
            chk("rst_vec",        i, int'(vec_s[i]),   0);
            rst_s[i] = 1'b0;
        end
        @(negedge clk);

        // SETTLE=1: clean sweep
        run_sweep(0, 0, 0, 1'b0, 0);
        // single fault at 0xB on output bit 1
        fault[0][11] = 3'b010;
        run_sweep(0, 0, 0, 1'b0, 0);
        clear_faults(0);
        // two faults: first one must be reported
        fault[0][3] = 3'b001;
        fault[0][9] = 3'b110;
        run_sweep(0, 0, 0, 1'b0, 0);
        clear_faults(0);
        // start+abort together, stray start at vec 2, abort at vec 5
        run_sweep(0, 1, 5, 1'b1, 2);
        // reset at vec 7 with one error already counted
        fault[0][2] = 3'b100;
        run_sweep(0, 2, 7, 1'b0, 0);
        clear_faults(0);
        // clean sweep after reset
        run_sweep(0, 0, 0, 1'b0, 0);
        // random sweeps
        for (int n = 0; n < 10; n++) begin
            random_tables(0);
            run_sweep(0, $urandom_range(0, 2), $urandom_range(1, 15), 1'($urandom_range(0, 1)), 0);
        end

        // SETTLE=3 with glitches on non-sampled cycles
        clear_faults(1);
        run_sweep(1, 0, 0, 1'b0, 0);
        fault[1][3] = 3'b001;
        fault[1][9] = 3'b110;
        run_sweep(1, 0, 0, 1'b0, 0);
        clear_faults(1);
        run_sweep(1, 1, 5, 1'b0, 6);
        for (int n = 0; n < 5; n++) begin
            random_tables(1);
            run_sweep(1, $urandom_range(0, 2), $urandom_range(1, 15), 1'b0, 0);
        end

        repeat (5) @(negedge clk);
        chk("queue_drain", 0, q0.size(), 0);
        chk("queue_drain", 1, q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/equiv_sweep_ctrl.md
Name: equiv_sweep_ctrl

Overview:
- Exhaustive equivalence sequencer for the team's combinational exercise blocks, which implement canonical and minimised forms of the same functions.
- Drives every input combination onto the block under test (BUT) and compares each canonical output against its minimised twin.
- Reports the mismatch count, the first failing vector and the first failing output mask.
- Sits between a start/done host (board switches/LEDs or bench) and one BUT instance.

Parameters:
- W_IN, 4, width of the input vector applied to the BUT (2^W_IN combinations swept).
- W_OUT, 3, number of canonical/minimised output pairs compared.
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  cancels a running sweep.
- vec  output  W_IN  input combination driven to the BUT.
- f_ref  input  W_OUT  BUT canonical outputs.
- f_min  input  W_OUT  BUT minimised outputs, bit i paired with f_ref[i].
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when a sweep completes (not on abort).
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_cnt  output  W_IN+1  number of vectors with at least one mismatching pair.
- first_vec  output  W_IN  first vector that mismatched.
- first_mask  output  W_OUT  f_ref XOR f_min captured at first_vec.

Behaviour:
- Reset values: state IDLE; vec=0, busy=0, done=0, pass=0, err_cnt=0, first_vec=0, first_mask=0.
- rst is synchronous and wins over start and abort in the same cycle; reset mid-sweep returns everything to reset values.
- FSM states: IDLE, RUN, FIN.
- IDLE: start=1 → RUN next cycle.
  - On entry to RUN: vec=0, settle counter=0, err_cnt=0, first_vec=0, first_mask=0, pass=0, busy=1.
- RUN: settle counter increments each cycle. In the cycle where the counter equals SETTLE-1, diff = f_ref ^ f_min is sampled at the clock edge.
  - If diff≠0: err_cnt increments.
  - If diff≠0 and err_cnt was 0 before this increment: first_vec=vec and first_mask=diff are captured.
  - Then the counter clears and vec increments.
  - If vec was all-ones (2^W_IN-1), state goes to FIN instead. vec does not wrap while in RUN and holds the last vector.
- Sweep timing: each vector is held exactly SETTLE cycles, so busy stays high for 2^W_IN*SETTLE cycles.
- FIN (one cycle): busy=0, done=1, pass=(err_cnt==0). The next state is IDLE.
  - done is high only during FIN.
  - pass, err_cnt, first_vec, first_mask and vec hold until the next start or reset.
- abort=1 in RUN: next cycle IDLE, busy=0, done stays 0, pass=0. err_cnt and first_* keep their partial values.
  - abort in IDLE or FIN has no effect.
- start in RUN or FIN is ignored.
- If start and abort are both high in IDLE, start wins.
- err_cnt cannot overflow: its maximum value 2^W_IN fits in W_IN+1 bits.
- Outputs are registered; vec reaches the BUT combinationally from the register.

Optional Feature:
- Macro: EQUIV_STOP_ON_FAIL_EN.
- When defined: the first mismatch ends the sweep immediately. The next state is FIN (done pulse, pass=0, err_cnt=1) and vec holds the failing vector so it can be inspected on board LEDs.
- When undefined: the full sweep always runs to completion as described in Behaviour.

Test Plan:
- Fault-free BUT model, W_IN=4, W_OUT=3, SETTLE=1; start pulse → busy high 16 cycles, vec steps 0..15, done pulse on the 17th cycle, pass=1, err_cnt=0.
- Same model with f_min[1] inverted only at vec=0xB → err_cnt=1, first_vec=0xB, first_mask=3'b010, pass=0.
- Faults at vec=3 (mask 3'b001) and vec=9 (mask 3'b110) → err_cnt=2, first_vec=3, first_mask=3'b001. The build with EQUIV_STOP_ON_FAIL_EN stops at vec=3 with err_cnt=1, done 4 cycles after start.
- SETTLE=3 → each vec value held 3 cycles, busy high 48 cycles, compare only on the third cycle of each vector. A glitch on f_min during the first two cycles of a vector is not counted.
- abort asserted while vec=5 → busy=0 next cycle, no done pulse, pass=0. A start pulse during the sweep is ignored and the vec sequence is undisturbed.
- rst asserted while vec=7 with err_cnt=1 → next cycle state IDLE and all outputs at reset values. A following start runs a clean full sweep.
